// File: rtl/vred_stream_unit.sv
// Streaming vector reduction: lane-wise accumulate of masked SEW elements, log2 fold
// to lane 0, then merge with the captured scalar seed and hand out one result.
`timescale 1ns/1ps
module vred_stream_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2,
  parameter int OP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    start_ready,
  input  logic [SEW_WIDTH-1:0]    sew,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic [DATA_WIDTH-1:0]   seed,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    flush,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FOLD, S_SEED, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [SEW_WIDTH-1:0]    sew_q, sew_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [63:0]             seed_q, seed_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [7:0]              step_q, step_d;
  int                      fold_k;

  function automatic logic [63:0] emask(input logic [SEW_WIDTH-1:0] s);
    if (s >= SEW_WIDTH'(3)) return '1;
    return (64'd1 << (8 << s)) - 64'd1;
  endfunction

  function automatic logic [63:0] ident(input logic [OP_WIDTH-1:0] o, input logic [SEW_WIDTH-1:0] s);
    logic [63:0] m;
    m = emask(s);
    case (o)
      OP_WIDTH'(1): return m;
      OP_WIDTH'(2): return m >> 1;
      OP_WIDTH'(4): return (m >> 1) ^ m;
      OP_WIDTH'(5): return m;
      default:      return '0;
    endcase
  endfunction

  // Elements are at most 64 bits, so one 64-bit container serves every SEW.
  function automatic logic [63:0] elem_f(input logic [63:0] a, input logic [63:0] b,
                                         input logic [OP_WIDTH-1:0] o, input logic [SEW_WIDTH-1:0] s);
    logic [63:0]        m, ua, ub, r;
    logic signed [63:0] sa, sb;
    int                 sh;
    m  = emask(s);
    sh = 64 - (8 << s);
    ua = a & m;
    ub = b & m;
    sa = $signed(ua << sh) >>> sh;
    sb = $signed(ub << sh) >>> sh;
    case (o)
      OP_WIDTH'(0): r = ua + ub;
      OP_WIDTH'(1): r = (ua < ub) ? ua : ub;
      OP_WIDTH'(2): r = (sa < sb) ? ua : ub;
      OP_WIDTH'(3): r = (ua > ub) ? ua : ub;
      OP_WIDTH'(4): r = (sa > sb) ? ua : ub;
      OP_WIDTH'(5): r = ua & ub;
      OP_WIDTH'(6): r = ua | ub;
      default:      r = ua ^ ub;
    endcase
    return r & m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] vec_f(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                                                  input logic [OP_WIDTH-1:0] o, input logic [SEW_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    logic [63:0]           t;
    r = '0;
    case (s)
      SEW_WIDTH'(0): for (int i = 0; i < NB; i++) begin
        t = elem_f(64'(a[i*8 +: 8]), 64'(b[i*8 +: 8]), o, s);  r[i*8 +: 8] = t[7:0];
      end
      SEW_WIDTH'(1): for (int i = 0; i < NB/2; i++) begin
        t = elem_f(64'(a[i*16 +: 16]), 64'(b[i*16 +: 16]), o, s);  r[i*16 +: 16] = t[15:0];
      end
      SEW_WIDTH'(2): for (int i = 0; i < NB/4; i++) begin
        t = elem_f(64'(a[i*32 +: 32]), 64'(b[i*32 +: 32]), o, s);  r[i*32 +: 32] = t[31:0];
      end
      default: for (int i = 0; i < NB/8; i++) begin
        r[i*64 +: 64] = elem_f(a[i*64 +: 64], b[i*64 +: 64], o, s);
      end
    endcase
    return r;
  endfunction

  // Disabled elements become the op identity so the lane update can be unconditional.
  function automatic logic [DATA_WIDTH-1:0] apply_mask(input logic [DATA_WIDTH-1:0] d, input logic [NB-1:0] msk,
                                                       input logic [OP_WIDTH-1:0] o, input logic [SEW_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    logic [63:0]           id, t;
    r  = '0;
    id = ident(o, s);
    case (s)
      SEW_WIDTH'(0): for (int i = 0; i < NB; i++) begin
        t = msk[i] ? 64'(d[i*8 +: 8]) : id;  r[i*8 +: 8] = t[7:0];
      end
      SEW_WIDTH'(1): for (int i = 0; i < NB/2; i++) begin
        t = msk[i] ? 64'(d[i*16 +: 16]) : id;  r[i*16 +: 16] = t[15:0];
      end
      SEW_WIDTH'(2): for (int i = 0; i < NB/4; i++) begin
        t = msk[i] ? 64'(d[i*32 +: 32]) : id;  r[i*32 +: 32] = t[31:0];
      end
      default: for (int i = 0; i < NB/8; i++) begin
        r[i*64 +: 64] = msk[i] ? d[i*64 +: 64] : id;
      end
    endcase
    return r;
  endfunction

  assign fold_k = $clog2(DATA_WIDTH) - 3 - int'(sew_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    sew_d   = sew_q;
    op_d    = op_q;
    seed_d  = seed_q;
    out_d   = out_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ACCUM;
        sew_d   = sew;
        op_d    = op;
        seed_d  = seed[63:0];
        acc_d   = apply_mask('0, '0, op, sew);
      end
      S_ACCUM: if (in_valid) begin
        acc_d  = vec_f(acc_q, apply_mask(in_data, in_mask, op_q, sew_q), op_q, sew_q);
        step_d = '0;
        if (in_last) state_d = (fold_k > 0) ? S_FOLD : S_SEED;
      end
      S_FOLD: begin
        // Upper half of the still-active lanes folds onto the lower half.
        acc_d  = vec_f(acc_q, acc_q >> (DATA_WIDTH >> (int'(step_q) + 1)), op_q, sew_q);
        step_d = step_q + 8'd1;
        if (int'(step_q) == fold_k - 1) state_d = S_SEED;
      end
      S_SEED: begin
        out_d   = DATA_WIDTH'(elem_f(acc_q[63:0], seed_q, op_q, sew_q));
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sew_q   <= '0;
      op_q    <= '0;
      seed_q  <= '0;
      out_q   <= '0;
      step_q  <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      sew_q   <= sew_d;
      op_q    <= op_d;
      seed_q  <= seed_d;
      out_q   <= out_d;
      step_q  <= step_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign in_ready    = (state_q == S_ACCUM);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign out_data    = out_q;

  a_sew_legal: assert property (@(posedge clk) disable iff (!rst)
    (start && state_q == S_IDLE) |-> ((32'd8 << sew) <= 32'(DATA_WIDTH)));

endmodule

// File: tb/tb_vred_stream_unit.sv
// Randomized self-checking bench for vred_stream_unit against an element-list reference model.
`timescale 1ns/1ps
module tb_vred_stream_unit;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start_ready, in_valid, in_ready, in_last;
  logic          out_valid, out_ready, flush, busy;
  logic [1:0]    sew;
  logic [2:0]    op;
  logic [DW-1:0] seed, in_data, out_data;
  logic [7:0]    in_mask;

  logic [63:0] bdata[8];
  logic [7:0]  bmask[8];
  int          nbeats;
  int          n_cmp = 0;
  int          n_bad = 0;

  vred_stream_unit #(.DATA_WIDTH(DW), .SEW_WIDTH(2), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .sew(sew), .op(op),
    .seed(seed), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mask(in_mask), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_mask(input int e);
    return (e == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << e) - 64'd1);
  endfunction

  function automatic longint m_signed(input logic [63:0] v, input int e);
    if (e == 64) return longint'(v);
    return v[e-1] ? (longint'(v) - (longint'(1) << e)) : longint'(v);
  endfunction

  function automatic logic [63:0] m_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] o, input int e);
    case (o)
      3'd0: return (a + b) & m_mask(e);
      3'd1: return (a < b) ? a : b;
      3'd2: return (m_signed(a, e) < m_signed(b, e)) ? a : b;
      3'd3: return (a > b) ? a : b;
      3'd4: return (m_signed(a, e) > m_signed(b, e)) ? a : b;
      3'd5: return a & b;
      3'd6: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Reduction order is irrelevant for these ops: fold every enabled element into the seed.
  function automatic logic [63:0] model(input logic [1:0] s, input logic [2:0] o, input logic [63:0] sd);
    int          e;
    logic [63:0] r, el;
    e = 8 << s;
    r = sd & m_mask(e);
    for (int b = 0; b < nbeats; b++)
      for (int i = 0; i < 64 / e; i++)
        if (bmask[b][i]) begin
          el = (bdata[b] >> (i * e)) & m_mask(e);
          r  = m_op(r, el, o, e);
        end
    return r;
  endfunction

  task automatic do_start(input logic [1:0] s, input logic [2:0] o, input logic [63:0] sd);
    bit ok = 0;
    start = 1'b1; sew = s; op = o; seed = sd;
    for (int c = 0; c < 20 && !ok; c++) begin
      ok = start_ready;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!ok) check("start_accept", 64'd0, 64'd1);
  endtask

  task automatic send_beats(input bit gaps);
    bit ok;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = bdata[b]; in_mask = bmask[b]; in_last = (b == nbeats - 1);
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
        ok = in_ready;
        @(posedge clk); #1;
      end
      if (!ok) check("beat_accept", 64'd0, 64'd1);
    end
    // Garbage on the beat port after the last beat must be ignored.
    in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
    in_data  = {$urandom, $urandom};
    in_mask  = 8'($urandom);
    in_last  = 1'b1;
  endtask

  task automatic run_red(input logic [1:0] s, input logic [2:0] o, input logic [63:0] sd,
                         input int hold, input bit pulse, input bit gaps, output logic [63:0] res);
    logic [63:0] exp;
    int          cyc;
    exp = model(s, o, sd);
    do_start(s, o, sd);
    send_beats(gaps);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    check("latency", 64'(cyc), 64'(4 - int'(s)));
    check("result", out_data, exp);
    res = out_data;
    for (int h = 0; h < hold; h++) begin
      if (pulse) begin
        start = 1'b1; sew = 2'($urandom); op = 3'($urandom); seed = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", out_data, exp);
      check("hold_start_ready", 64'(start_ready), 64'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_out", 64'({start_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic [63:0] res;
    bit          seen;
    rst = 1'b0; start = 0; sew = 0; op = 0; seed = 0; in_valid = 0; in_data = 0;
    in_mask = 0; in_last = 0; out_ready = 0; flush = 0;
    #12;
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_outs", 64'({busy, in_ready, out_valid}), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Sum of bytes 1..8 plus seed 5, full fold latency.
    nbeats = 1; bdata[0] = 64'h0807060504030201; bmask[0] = 8'hFF;
    run_red(2'd0, 3'd0, 64'h05, 0, 0, 0, res);
    check("tp1_sum", res, 64'h29);

    // Signed max over two beats, one masked element excluded.
    nbeats = 2;
    bdata[0] = 64'h0001_FFFF_0002_0003; bmask[0] = 8'h0F;
    bdata[1] = 64'h7FFF_0000_0000_0000; bmask[1] = 8'h07;
    run_red(2'd1, 3'd4, 64'h8000, 0, 0, 0, res);
    check("tp2_max", res, 64'h0003);

    nbeats = 1; bdata[0] = 64'h00000001_00000001; bmask[0] = 8'h03;
    run_red(2'd2, 3'd0, 64'hFFFFFFFF, 0, 0, 0, res);
    check("tp3_sum_wrap", res, 64'h00000001);
    run_red(2'd2, 3'd1, 64'hFFFFFFFF, 0, 0, 0, res);
    check("tp3_minu", res, 64'h00000001);
    run_red(2'd2, 3'd3, 64'hFFFFFFFF, 0, 0, 0, res);
    check("tp3_maxu", res, 64'hFFFFFFFF);

    nbeats = 1; bdata[0] = 64'hDEAD_BEEF_0000_0000; bmask[0] = 8'h00;
    run_red(2'd3, 3'd5, 64'h1234, 0, 0, 0, res);
    check("tp4_all_masked", res, 64'h1234);

    // Backpressure with start pulses while the result is held.
    nbeats = 1; bdata[0] = {$urandom, $urandom}; bmask[0] = 8'hFF;
    run_red(2'd0, 3'd6, 64'h0, 10, 1, 0, res);

    // Async reset mid-ACCUM: outputs drop before any clock edge.
    do_start(2'd0, 3'd0, 64'h0);
    in_valid = 1'b1; in_data = 64'h1; in_mask = 8'hFF; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_in_ready", 64'(in_ready), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_outs", 64'({in_ready, busy, out_valid}), 64'd0);
    check("rst_mid_start_ready", 64'(start_ready), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Flush in the second FOLD cycle discards the reduction.
    nbeats = 1; bdata[0] = 64'h0101010101010101; bmask[0] = 8'hFF;
    do_start(2'd0, 3'd0, 64'h0);
    send_beats(0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 64'({busy, start_ready}), 64'b01);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("flush_no_out", 64'(seen), 64'd0);
    bdata[0] = 64'h0807060504030201;
    run_red(2'd0, 3'd0, 64'h05, 0, 0, 0, res);
    check("after_flush_sum", res, 64'h29);

    // Randomized reductions.
    for (int t = 0; t < 40; t++) begin
      nbeats = $urandom_range(1, 4);
      for (int b = 0; b < nbeats; b++) begin
        bdata[b] = {$urandom, $urandom};
        bmask[b] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      end
      run_red(2'($urandom), 3'($urandom), {$urandom, $urandom},
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1, res);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vred_stream_unit.md
Name: vred_stream_unit

Overview:
Multi-beat vector reduction engine for the vALU, covering sum, signed/unsigned min/max and bitwise and/or/xor. It accepts a stream of DATA_WIDTH-bit source beats, each carrying packed SEW elements plus a per-element mask. Elements are combined lane-wise into an accumulator, folded to a single element by a log2 tree (one level per cycle), then merged with a scalar seed (vs1[0]). The single result is returned over a valid/ready handshake.

Parameters:
DATA_WIDTH, 64, beat width in bits; power of two, at least 64.
SEW_WIDTH, 2, width of the sew field; element bits = 8<<sew.
OP_WIDTH, 3, width of the op-select field.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous reset, active-low.
start  input  1  begin a reduction; accepted only when start_ready=1.
start_ready  output  1  high in IDLE only.
sew  input  SEW_WIDTH  element width; captured on the start handshake.
op  input  OP_WIDTH  000 sum, 001 minu, 010 min, 011 maxu, 100 max, 101 and, 110 or, 111 xor; captured on start.
seed  input  DATA_WIDTH  scalar operand, low SEW bits used; captured on start.
in_valid  input  1  source beat valid.
in_ready  output  1  high in ACCUM only.
in_data  input  DATA_WIDTH  packed elements; element i occupies bits [i*E +: E], where E = 8<<sew.
in_mask  input  DATA_WIDTH/8  bit i enables element i; bits at or above DATA_WIDTH/E are ignored.
in_last  input  1  marks the final beat.
out_valid  output  1  result valid.
out_ready  input  1  result consumed.
out_data  output  DATA_WIDTH  result in low E bits; upper bits are zero.
flush  input  1  synchronous abort to IDLE.
busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; accumulator=0; sew/op/seed registers=0; out_valid=0; out_data=0; in_ready=0; busy=0; start_ready=1.
- States and transitions:
  - IDLE: start&start_ready -> ACCUM. Capture sew, op, seed. Load every accumulator lane with the op identity.
  - ACCUM: on in_valid&in_ready, acc[i] = f(acc[i], masked elem i). A masked-off element contributes the identity. If in_last is also set -> FOLD when K>0, else SEED.
  - FOLD: K = log2(DATA_WIDTH/E) cycles. Each cycle combines the upper half of the active lanes into the lower half. Step counter runs 0..K-1, then -> SEED.
  - SEED: result = f(lane0, seed[E-1:0]) -> DONE.
  - DONE: out_valid=1. out_data is held stable until out_valid&out_ready -> IDLE (the next cycle).
- Identities per op: sum 0; minu all-ones; min 0111..1; maxu 0; max 1000..0; and all-ones; or 0; xor 0.
- Arithmetic and width rules:
  - sum wraps modulo 2^E; carries never cross element boundaries.
  - min/max compare signed or unsigned per op.
- Latency: out_valid rises K+1 cycles after the edge that accepts the last beat. Example: DATA_WIDTH=64, sew=0 gives 4 cycles; sew=3 gives 1 cycle.
- Beats: zero idle cycles are allowed between beats; there is no upper bound on beat count.
- An all-masked final beat is legal. A fully masked vector returns f(identity, seed) = seed.
- Ignored inputs:
  - start outside IDLE is ignored, including in DONE during the out handshake; a new start is accepted only once back in IDLE.
  - in_valid outside ACCUM is ignored (in_ready=0).
- flush: from any state -> IDLE next edge. out_valid drops, nothing is emitted, and the accumulator is discarded. flush has priority over every handshake in the same cycle.
- rst asserted mid-operation: all outputs go immediately to their reset values.
- sew with E > DATA_WIDTH is illegal; behaviour is undefined and flagged by an assertion in simulation.

Test Plan:
1. DATA_WIDTH=64, op=sum, sew=0, seed=0x05; one beat in_data=0x0807060504030201, in_mask=0xFF, in_last=1 -> out_data=0x29, out_valid exactly 4 cycles after the beat is accepted.
2. op=max, sew=1, seed=0x8000; beat0 0x0001_FFFF_0002_0003 mask 0xF; beat1 0x7FFF_0000_0000_0000 mask 0x7, in_last -> out_data=0x0003 (masked 0x7FFF excluded, 0xFFFF treated as -1).
3. op=sum, sew=2, seed=0xFFFFFFFF; beat 0x00000001_00000001 mask 0x3, in_last -> out_data=0x00000001 (wrap); repeat with op=minu -> 0x00000001; op=maxu -> 0xFFFFFFFF.
4. op=and, sew=3, seed=0x1234; one beat with mask=0x00, in_last -> out_data=0x1234, out_valid 1 cycle after the beat is accepted.
5. Backpressure: in DONE hold out_ready=0 for 10 cycles while pulsing start -> out_valid and out_data stay stable, start_ready=0, and no new capture occurs. Raise out_ready -> IDLE next cycle, start_ready=1.
6. Drive rst=0 mid-ACCUM -> in_ready, busy and out_valid drop without waiting for a clock edge. Separately, assert flush in the second FOLD cycle (sew=0) -> IDLE next edge, no out_valid pulse, and a following reduction is unaffected.
